// File: rtl/ssvep_multi_lockin_if.sv
// Sample/result bus of the multi-frequency SSVEP lock-in detector.
// Handshake: x is taken on every cycle x_valid is high (no backpressure); result_valid is a one-cycle pulse and amp_best/class_idx/detected hold until the next pulse.
interface ssvep_multi_lockin_if #(
    parameter int Q_IN   = 24,
    parameter int N_FREQ = 4,
    parameter int Q_ACC  = 48
);
    localparam int CIDX_W = (N_FREQ > 1) ? $clog2(N_FREQ) : 1;

    logic signed [Q_IN-1:0] x;
    logic                   x_valid;
    logic [Q_ACC:0]         thresh;
    logic [N_FREQ-1:0]      stim;
    logic [Q_ACC:0]         amp_best;
    logic [CIDX_W-1:0]      class_idx;
    logic                   detected;
    logic                   result_valid;
    logic                   busy;
    logic [1:0]             state_dbg;

    modport master (
        output x, x_valid, thresh,
        input  stim, amp_best, class_idx, detected, result_valid, busy, state_dbg
    );

    modport slave (
        input  x, x_valid, thresh,
        output stim, amp_best, class_idx, detected, result_valid, busy, state_dbg
    );
endinterface

// File: rtl/ssvep_multi_lockin.sv
// Square-wave I/Q lock-in over N_FREQ stimulus frequencies; after each window the
// channel with the largest |I|+|Q| is reported together with a threshold decision.
module ssvep_multi_lockin #(
    parameter int                   Q_IN   = 24,
    parameter int                   N_FREQ = 4,
    parameter logic [16*N_FREQ-1:0] M_LIST = {16'd62, 16'd83, 16'd100, 16'd125},
    parameter int                   WINDOW = 1000,
    parameter int                   Q_ACC  = 48
) (
    input logic                 clk,
    input logic                 reset,
    ssvep_multi_lockin_if.slave bus
);
    localparam int CIDX_W = (N_FREQ > 1) ? $clog2(N_FREQ) : 1;
    localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {S_ACC = 2'd0, S_CMP = 2'd1, S_OUT = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             ph_q [N_FREQ];
    logic [15:0]             ph_d [N_FREQ];
    logic signed [Q_ACC-1:0] acc_i_q [N_FREQ];
    logic signed [Q_ACC-1:0] acc_i_d [N_FREQ];
    logic signed [Q_ACC-1:0] acc_q_q [N_FREQ];
    logic signed [Q_ACC-1:0] acc_q_d [N_FREQ];
    logic signed [Q_ACC-1:0] snap_i_q [N_FREQ];
    logic signed [Q_ACC-1:0] snap_i_d [N_FREQ];
    logic signed [Q_ACC-1:0] snap_q_q [N_FREQ];
    logic signed [Q_ACC-1:0] snap_q_d [N_FREQ];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CIDX_W-1:0]       cmp_k_q, cmp_k_d;
    logic [CIDX_W-1:0]       best_idx_q, best_idx_d;
    logic [CIDX_W-1:0]       class_idx_q, class_idx_d;
    logic [Q_ACC:0]          best_amp_q, best_amp_d;
    logic [Q_ACC:0]          amp_best_q, amp_best_d;
    logic                    detected_q, detected_d;
    logic                    result_valid_q, result_valid_d;

    logic signed [Q_ACC-1:0] x_ext;
    logic                    win_close;
    logic [N_FREQ-1:0]       ref_i, ref_q;
    logic [Q_ACC:0]          amp_cur;

    function automatic logic [15:0] m_of(input int k);
        return M_LIST[16*k +: 16];
    endfunction

    function automatic logic ref_at(input logic [15:0] p, input logic [15:0] m);
        return p < (m >> 1);
    endfunction

    // Quadrature phase: (p + M - M/4) mod M, kept in 17 bits to avoid wrap.
    function automatic logic [15:0] q_phase(input logic [15:0] p, input logic [15:0] m);
        logic [16:0] s;
        s = {1'b0, p} + {1'b0, m} - {3'b000, m[15:2]};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[15:0];
    endfunction

    function automatic logic [Q_ACC-1:0] mag(input logic signed [Q_ACC-1:0] v);
        return v[Q_ACC-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    assign x_ext     = {{(Q_ACC-Q_IN){bus.x[Q_IN-1]}}, bus.x};
    assign win_close = bus.x_valid && (cnt_q == CNT_W'(WINDOW-1));
    assign amp_cur   = {1'b0, mag(snap_i_q[cmp_k_q])} + {1'b0, mag(snap_q_q[cmp_k_q])};

    always_comb begin
        ref_i = '0;
        ref_q = '0;
        for (int k = 0; k < N_FREQ; k++) begin
            ref_i[k] = ref_at(ph_q[k], m_of(k));
            ref_q[k] = ref_at(q_phase(ph_q[k], m_of(k)), m_of(k));
        end
    end

    always_comb begin
        state_d        = state_q;
        ph_d           = ph_q;
        acc_i_d        = acc_i_q;
        acc_q_d        = acc_q_q;
        snap_i_d       = snap_i_q;
        snap_q_d       = snap_q_q;
        cnt_d          = cnt_q;
        cmp_k_d        = cmp_k_q;
        best_idx_d     = best_idx_q;
        best_amp_d     = best_amp_q;
        amp_best_d     = amp_best_q;
        class_idx_d    = class_idx_q;
        detected_d     = detected_q;
        result_valid_d = 1'b0;

        // Accumulation runs in every state so samples during CMP/OUT join the next window.
        if (bus.x_valid) begin
            cnt_d = win_close ? '0 : cnt_q + 1'b1;
            for (int k = 0; k < N_FREQ; k++) begin
                ph_d[k]    = (ph_q[k] == m_of(k) - 16'd1) ? '0 : ph_q[k] + 16'd1;
                acc_i_d[k] = ref_i[k] ? acc_i_q[k] + x_ext : acc_i_q[k] - x_ext;
                acc_q_d[k] = ref_q[k] ? acc_q_q[k] + x_ext : acc_q_q[k] - x_ext;
                if (win_close) begin
                    snap_i_d[k] = acc_i_d[k];
                    snap_q_d[k] = acc_q_d[k];
                    acc_i_d[k]  = '0;
                    acc_q_d[k]  = '0;
                end
            end
        end

        case (state_q)
            S_ACC: begin
                if (win_close) begin
                    state_d = S_CMP;
                    cmp_k_d = '0;
                end
            end
            S_CMP: begin
                // Strict > keeps the lowest index on ties.
                if (cmp_k_q == '0 || amp_cur > best_amp_q) begin
                    best_amp_d = amp_cur;
                    best_idx_d = cmp_k_q;
                end
                if (cmp_k_q == CIDX_W'(N_FREQ-1)) state_d = S_OUT;
                else                              cmp_k_d = cmp_k_q + 1'b1;
            end
            S_OUT: begin
                amp_best_d     = best_amp_q;
                class_idx_d    = best_idx_q;
                detected_d     = (best_amp_q >= bus.thresh);
                result_valid_d = 1'b1;
                state_d        = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_ACC;
            cnt_q          <= '0;
            cmp_k_q        <= '0;
            best_idx_q     <= '0;
            best_amp_q     <= '0;
            amp_best_q     <= '0;
            class_idx_q    <= '0;
            detected_q     <= 1'b0;
            result_valid_q <= 1'b0;
            for (int k = 0; k < N_FREQ; k++) begin
                ph_q[k]     <= '0;
                acc_i_q[k]  <= '0;
                acc_q_q[k]  <= '0;
                snap_i_q[k] <= '0;
                snap_q_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmp_k_q        <= cmp_k_d;
            best_idx_q     <= best_idx_d;
            best_amp_q     <= best_amp_d;
            amp_best_q     <= amp_best_d;
            class_idx_q    <= class_idx_d;
            detected_q     <= detected_d;
            result_valid_q <= result_valid_d;
            ph_q           <= ph_d;
            acc_i_q        <= acc_i_d;
            acc_q_q        <= acc_q_d;
            snap_i_q       <= snap_i_d;
            snap_q_q       <= snap_q_d;
        end
    end

    assign bus.stim         = ref_i;
    assign bus.amp_best     = amp_best_q;
    assign bus.class_idx    = class_idx_q;
    assign bus.detected     = detected_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != S_ACC);
    assign bus.state_dbg    = state_q;
endmodule
